// File: rtl/credential_enroll_pkg.sv
// Shared definitions for the credential enrollment block: defaults, state
// encoding and the state-to-display mapping.
package credential_enroll_pkg;

  localparam int unsigned IdWDef      = 4;
  localparam int unsigned PwWDef      = 4;
  localparam int unsigned NumUsersDef = 16;
  localparam int unsigned MaxTriesDef = 3;

  // Display codes; DONE and FAIL intentionally share 7.
  localparam logic [2:0] StageIdle  = 3'd0;
  localparam logic [2:0] StageGetId = 3'd1;
  localparam logic [2:0] StageLook  = 3'd2;
  localparam logic [2:0] StageOld   = 3'd3;
  localparam logic [2:0] StageNew   = 3'd4;
  localparam logic [2:0] StageConf  = 3'd5;
  localparam logic [2:0] StageWrite = 3'd6;
  localparam logic [2:0] StageEnd   = 3'd7;

  typedef enum logic [3:0] {
    StIdle,
    StGetId,
    StLookup,
    StGetOld,
    StGetNew,
    StGetConf,
    StWrite,
    StDone,
    StFail
  } state_e;

  function automatic logic [2:0] stage_of(state_e s);
    logic [2:0] code;
    case (s)
      StIdle:    code = StageIdle;
      StGetId:   code = StageGetId;
      StLookup:  code = StageLook;
      StGetOld:  code = StageOld;
      StGetNew:  code = StageNew;
      StGetConf: code = StageConf;
      StWrite:   code = StageWrite;
      default:   code = StageEnd;
    endcase
    return code;
  endfunction

  function automatic logic is_busy(state_e s);
    return (s == StGetId) || (s == StLookup) || (s == StGetOld) ||
           (s == StGetNew) || (s == StGetConf) || (s == StWrite);
  endfunction

endpackage

// File: rtl/credential_enroll_if.sv
// Credential store port: registered read address with one-cycle read data,
// plus a single-cycle write strobe.
interface credential_enroll_if #(
  parameter int unsigned ID_W = 4,
  parameter int unsigned PW_W = 4
);
  logic [ID_W-1:0] rd_addr;
  logic [PW_W-1:0] rd_data;
  logic            wr_en;
  logic [ID_W-1:0] wr_addr;
  logic [PW_W-1:0] wr_data;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/enroll_try_counter.sv
// Saturating count of consecutive old-password failures with lockout flag.
module enroll_try_counter #(
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o,
  output logic locked_o
);

  localparam int unsigned CntW = $clog2(MAX_TRIES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign locked_o = (cnt_q == CntW'(MAX_TRIES));
  // One more failure from here means lockout.
  assign last_o   = (cnt_q == CntW'(MAX_TRIES - 1));

  // Clear wins over increment; hold once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !locked_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/credential_enroll.sv
// Password-change sequencer: verify old password for a user ID, take the new
// password twice, and issue one store write when both entries agree.
module credential_enroll
  import credential_enroll_pkg::*;
#(
  parameter int unsigned ID_W      = IdWDef,
  parameter int unsigned PW_W      = PwWDef,
  parameter int unsigned NUM_USERS = NumUsersDef,
  parameter int unsigned MAX_TRIES = MaxTriesDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enroll_en,
  input  logic [ID_W-1:0]     in_toggle_userid,
  input  logic [PW_W-1:0]     in_toggle_pswd,
  input  logic                userid_btn,
  input  logic                pswd_btn,
  input  logic                timeout,
  credential_enroll_if.master store,
  output logic                busy,
  output logic                greenled,
  output logic                redled,
  output logic [2:0]          stage
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rd_addr_q, rd_addr_d;
  logic            wr_en_q, wr_en_d;
  logic [ID_W-1:0] wr_addr_q, wr_addr_d;
  logic [PW_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [PW_W-1:0] new_pw_q, new_pw_d;
  logic            green_q, green_d;
  logic            red_q, red_d;
  logic            busy_q;
  logic [2:0]      stage_q;
  logic            try_clr, try_inc, try_last, try_locked;
  logic            abortable;

  enroll_try_counter #(
    .MAX_TRIES (MAX_TRIES)
  ) u_try_counter (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (try_clr),
    .inc_i    (try_inc),
    .last_o   (try_last),
    .locked_o (try_locked)
  );

  // WRITE is excluded: its strobe is already on the bus, so it always completes.
  assign abortable = is_busy(state_q) && (state_q != StWrite);

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    id_d      = id_q;
    new_pw_d  = new_pw_q;
    green_d   = green_q;
    red_d     = red_q;
    try_clr   = 1'b0;
    try_inc   = 1'b0;

    if (abortable && !enroll_en) begin
      state_d = StIdle;
    end else if (abortable && timeout) begin
      red_d   = 1'b1;
      state_d = StFail;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enroll_en) begin
            green_d = 1'b0;
            red_d   = 1'b0;
            state_d = StGetId;
          end
        end
        StGetId: begin
          if (userid_btn) begin
            id_d = in_toggle_userid;
            if (32'(in_toggle_userid) < NUM_USERS) begin
              rd_addr_d = in_toggle_userid;
              state_d   = StLookup;
            end else begin
              red_d   = 1'b1;
              state_d = StFail;
            end
          end
        end
        StLookup: begin
          // A locked-out counter skips the password prompt entirely.
          if (try_locked) begin
            red_d   = 1'b1;
            state_d = StFail;
          end else begin
            state_d = StGetOld;
          end
        end
        StGetOld: begin
          if (pswd_btn) begin
            if (in_toggle_pswd == store.rd_data) begin
              try_clr = 1'b1;
              state_d = StGetNew;
            end else begin
              try_inc = 1'b1;
              if (try_last) begin
                red_d   = 1'b1;
                state_d = StFail;
              end
            end
          end
        end
        StGetNew: begin
          if (pswd_btn) begin
            new_pw_d = in_toggle_pswd;
            state_d  = StGetConf;
          end
        end
        StGetConf: begin
          if (pswd_btn) begin
            if (in_toggle_pswd == new_pw_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = id_q;
              wr_data_d = new_pw_q;
              state_d   = StWrite;
            end else begin
              state_d = StGetNew;
            end
          end
        end
        StWrite: begin
          green_d = 1'b1;
          state_d = StDone;
        end
        StDone, StFail: begin
          if (!enroll_en) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      id_q      <= '0;
      new_pw_q  <= '0;
      green_q   <= 1'b0;
      red_q     <= 1'b0;
      busy_q    <= 1'b0;
      stage_q   <= StageIdle;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      id_q      <= id_d;
      new_pw_q  <= new_pw_d;
      green_q   <= green_d;
      red_q     <= red_d;
      busy_q    <= is_busy(state_d);
      stage_q   <= stage_of(state_d);
    end
  end

  assign store.rd_addr = rd_addr_q;
  assign store.wr_en   = wr_en_q;
  assign store.wr_addr = wr_addr_q;
  assign store.wr_data = wr_data_q;
  assign busy          = busy_q;
  assign greenled      = green_q;
  assign redled        = red_q;
  assign stage         = stage_q;

endmodule

// File: tb/tb_credential_enroll.sv
// Directed bench for credential_enroll with a small synchronous-read store.
module tb_credential_enroll;

  logic       clk = 1'b0;
  logic       rst;
  logic       enroll_en;
  logic [3:0] in_toggle_userid;
  logic [3:0] in_toggle_pswd;
  logic       userid_btn;
  logic       pswd_btn;
  logic       timeout;
  logic       busy;
  logic       greenled;
  logic       redled;
  logic [2:0] stage;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [3:0] mem [16];

  credential_enroll_if #(.ID_W(4), .PW_W(4)) sif ();

  credential_enroll #(
    .ID_W      (4),
    .PW_W      (4),
    .NUM_USERS (8),
    .MAX_TRIES (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enroll_en        (enroll_en),
    .in_toggle_userid (in_toggle_userid),
    .in_toggle_pswd   (in_toggle_pswd),
    .userid_btn       (userid_btn),
    .pswd_btn         (pswd_btn),
    .timeout          (timeout),
    .store            (sif),
    .busy             (busy),
    .greenled         (greenled),
    .redled           (redled),
    .stage            (stage)
  );

  always #5 clk = ~clk;

  // Store: write on strobe, read data one cycle after the address.
  always @(posedge clk) begin
    if (sif.wr_en === 1'b1) begin
      mem[sif.wr_addr] <= sif.wr_data;
      wr_count         <= wr_count + 1;
    end
    sif.rd_data <= mem[sif.rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_id(input logic [3:0] v);
    in_toggle_userid = v;
    userid_btn       = 1'b1;
    tick();
    userid_btn       = 1'b0;
  endtask

  task automatic pulse_pw(input logic [3:0] v);
    in_toggle_pswd = v;
    pswd_btn       = 1'b1;
    tick();
    pswd_btn       = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    mem[5]           = 4'hA;
    rst              = 1'b0;
    enroll_en        = 1'b0;
    in_toggle_userid = '0;
    in_toggle_pswd   = '0;
    userid_btn       = 1'b0;
    pswd_btn         = 1'b0;
    timeout          = 1'b0;
    tick();
    tick();
    chk("reset_stage", stage, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", sif.wr_en, 0);
    chk("reset_rd_addr", sif.rd_addr, 0);
    chk("reset_leds", {greenled, redled}, 0);
    rst = 1'b1;
    tick();

    // Happy path: ID 5, old 0xA, new 0x3 twice.
    enroll_en = 1'b1;
    tick();
    chk("hp_get_id", stage, 1);
    chk("hp_busy", busy, 1);
    pulse_id(4'd5);
    chk("hp_lookup", stage, 2);
    chk("hp_rd_addr", sif.rd_addr, 5);
    tick();
    chk("hp_get_old", stage, 3);
    pulse_pw(4'hA);
    chk("hp_get_new", stage, 4);
    pulse_pw(4'h3);
    chk("hp_get_conf", stage, 5);
    chk("hp_no_wr_early", sif.wr_en, 0);
    pulse_pw(4'h3);
    chk("hp_write_stage", stage, 6);
    chk("hp_wr_en", sif.wr_en, 1);
    chk("hp_wr_addr", sif.wr_addr, 5);
    chk("hp_wr_data", sif.wr_data, 3);
    tick();
    chk("hp_done_stage", stage, 7);
    chk("hp_wr_en_off", sif.wr_en, 0);
    chk("hp_leds", {greenled, redled}, 2'b10);
    chk("hp_busy_off", busy, 0);
    chk("hp_wr_count", wr_count, 1);
    chk("hp_store", mem[5], 4'h3);
    enroll_en = 1'b0;
    tick();
    chk("hp_idle", stage, 0);
    chk("hp_green_held", greenled, 1);

    // Confirm mismatch, then simultaneous buttons, then a good retry.
    enroll_en = 1'b1;
    tick();
    chk("cm_green_clr", greenled, 0);
    pulse_id(4'd5);
    tick();
    pulse_pw(4'h3);
    chk("cm_get_new", stage, 4);
    pulse_pw(4'h3);
    pulse_pw(4'h4);
    chk("cm_back_new", stage, 4);
    chk("cm_no_wr", wr_count, 1);
    in_toggle_userid = 4'd2;
    in_toggle_pswd   = 4'h6;
    userid_btn       = 1'b1;
    pswd_btn         = 1'b1;
    tick();
    userid_btn       = 1'b0;
    pswd_btn         = 1'b0;
    chk("cm_both_btn", stage, 5);
    pulse_pw(4'h6);
    chk("cm_wr_en", sif.wr_en, 1);
    chk("cm_wr_addr", sif.wr_addr, 5);
    chk("cm_wr_data", sif.wr_data, 6);
    tick();
    chk("cm_wr_count", wr_count, 2);
    chk("cm_green", greenled, 1);
    enroll_en = 1'b0;
    tick();

    // Invalid ID with NUM_USERS=8.
    enroll_en = 1'b1;
    tick();
    pulse_id(4'd9);
    chk("inv_stage", stage, 7);
    chk("inv_leds", {greenled, redled}, 2'b01);
    chk("inv_rd_addr", sif.rd_addr, 5);
    enroll_en = 1'b0;
    tick();
    chk("inv_idle", stage, 0);
    chk("inv_red_held", redled, 1);

    // Timeout in GET_CONF beats a simultaneous matching confirm.
    enroll_en = 1'b1;
    tick();
    pulse_pw(4'h1);
    chk("to_ignore_pw", stage, 1);
    pulse_id(4'd5);
    tick();
    pulse_pw(4'h6);
    pulse_pw(4'h2);
    chk("to_get_conf", stage, 5);
    in_toggle_pswd = 4'h2;
    pswd_btn       = 1'b1;
    timeout        = 1'b1;
    tick();
    pswd_btn       = 1'b0;
    timeout        = 1'b0;
    chk("to_stage", stage, 7);
    chk("to_red", redled, 1);
    chk("to_wr_en", sif.wr_en, 0);
    tick();
    chk("to_wr_count", wr_count, 2);
    enroll_en = 1'b0;
    tick();

    // Abort in GET_NEW.
    enroll_en = 1'b1;
    tick();
    pulse_id(4'd5);
    tick();
    pulse_pw(4'h6);
    chk("ab_get_new", stage, 4);
    enroll_en = 1'b0;
    tick();
    chk("ab_idle", stage, 0);
    chk("ab_busy", busy, 0);
    chk("ab_leds", {greenled, redled}, 2'b00);
    chk("ab_wr_count", wr_count, 2);

    // Lockout: three wrong old passwords, then correct one still fails.
    enroll_en = 1'b1;
    tick();
    pulse_id(4'd5);
    tick();
    pulse_pw(4'h0);
    chk("lo_try1", stage, 3);
    pulse_pw(4'h1);
    chk("lo_try2", stage, 3);
    chk("lo_red_early", redled, 0);
    pulse_pw(4'h2);
    chk("lo_fail", stage, 7);
    chk("lo_red", redled, 1);
    enroll_en = 1'b0;
    tick();
    enroll_en = 1'b1;
    tick();
    pulse_id(4'd5);
    tick();
    chk("lo_relock", stage, 7);
    chk("lo_relock_red", redled, 1);
    chk("lo_wr_count", wr_count, 2);
    enroll_en = 1'b0;
    tick();

    // Reset clears tries; then async reset during WRITE.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    enroll_en = 1'b1;
    tick();
    pulse_id(4'd5);
    tick();
    pulse_pw(4'h6);
    chk("rs_unlocked", stage, 4);
    pulse_pw(4'h9);
    pulse_pw(4'h9);
    chk("rs_in_write", sif.wr_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rs_wr_en", sif.wr_en, 0);
    chk("rs_stage", stage, 0);
    chk("rs_busy", busy, 0);
    chk("rs_addrs", {sif.rd_addr, sif.wr_addr, sif.wr_data}, 0);
    chk("rs_leds", {greenled, redled}, 0);
    tick();
    chk("rs_wr_count", wr_count, 2);
    chk("rs_store", mem[5], 4'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
